// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// the hardwired-zero register address and the flattened-bus index helper.
package rf_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REGS   = 32;
    localparam int ZERO_ADDR      = 0;

    // Bit offset of element idx inside a bus of packed width-bit elements.
    function automatic int lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port of regfile_mp: write-to-read bypass with highest-port
// priority, zero-register forcing and an optional one-cycle output register.
// The busy flag is taken from the next-state scoreboard vector, which already
// folds in this cycle's clears, sets and flush.
module regfile_rdport
    import rf_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  NUM_REGS   = DEF_NUM_REGS,
    parameter int  NUM_WR     = 2,
    parameter int  RD_REG     = 0,
    parameter int  ZERO_REG   = 1,
    localparam int ADDR_W     = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
    input  logic [NUM_REGS-1:0]          busy_nxt,
    input  logic [NUM_WR-1:0]            wen,
    input  logic [NUM_WR*ADDR_W-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0]        data,
    output logic                         busy
);

    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_busy;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  busy_q;
    logic                  is_zero;

    assign is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_ADDR));

    // Stored value, overridden by the highest-index enabled writer, then zero forcing.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel_data = regs_flat[lsb(int'(addr), DATA_WIDTH) +: DATA_WIDTH];
        for (int w = 0; w < NUM_WR; w++) begin
            if (wen[w] && (wr_addr[lsb(w, ADDR_W) +: ADDR_W] == addr)) begin
                sel_data = wr_data[lsb(w, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
        if (is_zero) begin
            sel_data = '0;
        end
        sel_busy = busy_nxt[addr];
    end

    // Output register for the registered-read mode; optimised away when unused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= sel_data;
            busy_q <= sel_busy;
        end
    end

    // Outputs are held at zero for the whole reset interval in both modes.
    assign data = rst ? '0   : ((RD_REG != 0) ? data_q : sel_data);
    assign busy = rst ? 1'b0 : ((RD_REG != 0) ? busy_q : sel_busy);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, optional
// registered reads and a per-register busy scoreboard for RAW stall checks.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  NUM_REGS   = DEF_NUM_REGS,
    parameter int  NUM_RD     = 2,
    parameter int  NUM_WR     = 2,
    parameter int  RD_REG     = 0,
    parameter int  ZERO_REG   = 1,
    localparam int ADDR_W     = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*ADDR_W-1:0]     rs_addr_i_idu_rf,
    output logic [NUM_RD*DATA_WIDTH-1:0] rs_data_o_rf_idu,
    output logic [NUM_RD-1:0]            rs_busy_o_rf_idu,
    input  logic [NUM_WR-1:0]            wen_i_wb_rf,
    input  logic [NUM_WR*ADDR_W-1:0]     rd_addr_i_wb_rf,
    input  logic [NUM_WR*DATA_WIDTH-1:0] rd_data_i_wb_rf,
    input  logic                         sb_set_i_idu_rf,
    input  logic [ADDR_W-1:0]            sb_addr_i_idu_rf,
    input  logic                         sb_flush_i
);

    logic [DATA_WIDTH-1:0]          regs [NUM_REGS];
    logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat;
    logic [NUM_REGS-1:0]            busy_q;
    logic [NUM_REGS-1:0]            busy_nxt;

    // Storage: enabled writes applied in port order so the highest index wins.
    // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
    // NOTE: the array is reset because software relies on registers reading zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wen_i_wb_rf[w] &&
                    !((ZERO_REG != 0) &&
                      (rd_addr_i_wb_rf[lsb(w, ADDR_W) +: ADDR_W] == ADDR_W'(ZERO_ADDR)))) begin
                    regs[rd_addr_i_wb_rf[lsb(w, ADDR_W) +: ADDR_W]] <=
                        rd_data_i_wb_rf[lsb(w, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end
    end

    // Scoreboard next state: writeback clears, issue set wins, flush beats everything.
    always_comb begin
        busy_nxt = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wen_i_wb_rf[w]) begin
                busy_nxt[rd_addr_i_wb_rf[lsb(w, ADDR_W) +: ADDR_W]] = 1'b0;
            end
        end
        if (sb_set_i_idu_rf) begin
            busy_nxt[sb_addr_i_idu_rf] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_nxt[ZERO_ADDR] = 1'b0;
        end
        if (sb_flush_i) begin
            busy_nxt = '0;
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    // Flatten storage so each read port can index it as a plain vector.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
        assign regs_flat[lsb(r, DATA_WIDTH) +: DATA_WIDTH] = regs[r];
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_rdport #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_REGS   (NUM_REGS),
            .NUM_WR     (NUM_WR),
            .RD_REG     (RD_REG),
            .ZERO_REG   (ZERO_REG)
        ) u_rdport (
            .clk       (clk),
            .rst       (rst),
            .addr      (rs_addr_i_idu_rf[lsb(k, ADDR_W) +: ADDR_W]),
            .regs_flat (regs_flat),
            .busy_nxt  (busy_nxt),
            .wen       (wen_i_wb_rf),
            .wr_addr   (rd_addr_i_wb_rf),
            .wr_data   (rd_data_i_wb_rf),
            .data      (rs_data_o_rf_idu[lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
            .busy      (rs_busy_o_rf_idu[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a combinational-read and a registered-read instance
// share stimulus and are compared against an array-based reference model.
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NRD*AW-1:0] rs_addr;
    logic [NWR-1:0]    wen;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic              sb_set;
    logic [AW-1:0]     sb_addr;
    logic              sb_flush;
    logic [NRD*DW-1:0] data_c, data_r;
    logic [NRD-1:0]    busy_c, busy_r;

    always #5 clk = ~clk;

    regfile_mp #(.RD_REG(0)) u_comb (
        .clk(clk), .rst(rst),
        .rs_addr_i_idu_rf(rs_addr), .rs_data_o_rf_idu(data_c), .rs_busy_o_rf_idu(busy_c),
        .wen_i_wb_rf(wen), .rd_addr_i_wb_rf(wr_addr), .rd_data_i_wb_rf(wr_data),
        .sb_set_i_idu_rf(sb_set), .sb_addr_i_idu_rf(sb_addr), .sb_flush_i(sb_flush)
    );

    regfile_mp #(.RD_REG(1)) u_reg (
        .clk(clk), .rst(rst),
        .rs_addr_i_idu_rf(rs_addr), .rs_data_o_rf_idu(data_r), .rs_busy_o_rf_idu(busy_r),
        .wen_i_wb_rf(wen), .rd_addr_i_wb_rf(wr_addr), .rd_data_i_wb_rf(wr_data),
        .sb_set_i_idu_rf(sb_set), .sb_addr_i_idu_rf(sb_addr), .sb_flush_i(sb_flush)
    );

    // Reference model state.
    logic [DW-1:0] m_mem [NR];
    bit            m_busy [NR];
    logic [DW-1:0] prev_data [NRD];
    bit            prev_busy [NRD];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        for (int k = 0; k < NRD; k++) begin
            prev_data[k] = '0;
            prev_busy[k] = 1'b0;
        end
    endtask

    function automatic int waddr(input int w);
        return int'(wr_addr[w*AW +: AW]);
    endfunction

    // What a read of register a should return right now: last enabled writer to a, else memory.
    function automatic logic [31:0] exp_data(input int a);
        logic [31:0] v;
        if (a == 0) return '0;
        v = m_mem[a];
        for (int w = 0; w < NWR; w++)
            if (wen[w] && waddr(w) == a) v = wr_data[w*DW +: DW];
        return v;
    endfunction

    // Busy as it will stand after this edge.
    function automatic bit exp_busy(input int a);
        bit written;
        if (sb_flush || a == 0) return 1'b0;
        if (sb_set && int'(sb_addr) == a) return 1'b1;
        written = 1'b0;
        for (int w = 0; w < NWR; w++)
            if (wen[w] && waddr(w) == a) written = 1'b1;
        return written ? 1'b0 : m_busy[a];
    endfunction

    task automatic commit();
        for (int w = 0; w < NWR; w++)
            if (wen[w] && waddr(w) != 0) m_mem[waddr(w)] = wr_data[w*DW +: DW];
        if (sb_flush) begin
            for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        end else begin
            for (int w = 0; w < NWR; w++)
                if (wen[w]) m_busy[waddr(w)] = 1'b0;
            if (sb_set && sb_addr != '0) m_busy[sb_addr] = 1'b1;
        end
    endtask

    // Check both instances against the model, then advance one clock.
    task automatic step(input string tag);
        logic [31:0] ed [NRD];
        bit          eb [NRD];
        int          a;
        #2;
        for (int k = 0; k < NRD; k++) begin
            a = int'(rs_addr[k*AW +: AW]);
            ed[k] = exp_data(a);
            eb[k] = exp_busy(a);
            check({tag, "_cdata"}, data_c[k*DW +: DW], ed[k]);
            check({tag, "_cbusy"}, 32'(busy_c[k]), 32'(eb[k]));
            check({tag, "_rdata"}, data_r[k*DW +: DW], prev_data[k]);
            check({tag, "_rbusy"}, 32'(busy_r[k]), 32'(prev_busy[k]));
        end
        @(posedge clk);
        for (int k = 0; k < NRD; k++) begin
            prev_data[k] = ed[k];
            prev_busy[k] = eb[k];
        end
        commit();
        @(negedge clk);
    endtask

    task automatic idle();
        wen      = '0;
        sb_set   = 1'b0;
        sb_flush = 1'b0;
    endtask

    task automatic wr(input int w, input logic [AW-1:0] a, input logic [31:0] d);
        wen[w]              = 1'b1;
        wr_addr[w*AW +: AW] = a;
        wr_data[w*DW +: DW] = d;
    endtask

    task automatic rd(input int k, input logic [AW-1:0] a);
        rs_addr[k*AW +: AW] = a;
    endtask

    task automatic sb(input logic [AW-1:0] a);
        sb_set  = 1'b1;
        sb_addr = a;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cdata"}, data_c[31:0] | data_c[63:32], 32'h0);
        check({tag, "_rdata"}, data_r[31:0] | data_r[63:32], 32'h0);
        check({tag, "_busy"},  32'({busy_c, busy_r}), 32'h0);
    endtask

    initial begin
        idle();
        rs_addr = '0; wr_addr = '0; wr_data = '0; sb_addr = '0;
        model_reset();

        // Reset state, with a write and a set attempted while in reset.
        wr(0, 5'd1, 32'hCAFE); sb(5'd1); rd(0, 5'd1);
        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        idle();
        rst = 1'b0;
        step("rst_rel");

        // Reset mid-run: reg5 written, then async reset with a write to reg2 pending.
        wr(0, 5'd5, 32'h1234); step("w5");
        idle(); rd(0, 5'd5); rd(1, 5'd2); wr(1, 5'd2, 32'hBEEF);
        #1;
        check("pre_rst_r5", data_c[31:0], 32'h1234);
        check("pre_rst_byp", data_c[63:32], 32'hBEEF);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk); #1;
        check_all_zero("rst_edge");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle();
        #1;
        check("r5_after_rst", data_c[31:0], 32'h0);
        check("r2_not_written", data_c[63:32], 32'h0);
        step("post_rst");

        // Register 0 stays zero.
        wr(0, 5'd0, 32'hFFFF); rd(0, 5'd0); step("w0");
        idle(); #1;
        check("r0_zero", data_c[31:0], 32'h0);
        check("r0_zero_reg", data_r[31:0], 32'h0);
        step("r0");

        // Bypass with both write ports hitting reg3.
        wr(0, 5'd3, 32'hAAAA); wr(1, 5'd3, 32'h5555); rd(0, 5'd3); rd(1, 5'd3);
        #1;
        check("byp_p0", data_c[31:0], 32'h5555);
        check("byp_p1", data_c[63:32], 32'h5555);
        step("byp");
        idle(); #1;
        check("byp_stored", data_c[31:0], 32'h5555);
        check("byp_regd", data_r[63:32], 32'h5555);
        step("byp2");

        // Registered read of reg7 written in the sampling cycle.
        rd(0, 5'd7); step("r7a");
        wr(0, 5'd7, 32'hDEAD); #1;
        check("rreg_pre", data_r[31:0], 32'h0);
        step("r7b");
        idle(); #1;
        check("rreg_post", data_r[31:0], 32'hDEAD);
        step("r7c");

        // Scoreboard set / set-with-clear / clear.
        sb(5'd9); rd(0, 5'd9); step("sb_a");
        idle(); #1;
        check("sb_set", 32'(busy_c[0]), 32'h1);
        check("sb_set_reg", 32'(busy_r[0]), 32'h1);
        step("sb_b");
        wr(1, 5'd9, 32'h99); sb(5'd9); #1;
        check("sb_set_wins", 32'(busy_c[0]), 32'h1);
        step("sb_c");
        idle(); #1;
        check("sb_keep", 32'(busy_c[0]), 32'h1);
        step("sb_d");
        wr(0, 5'd9, 32'h77); #1;
        check("sb_clr_byp", 32'(busy_c[0]), 32'h0);
        step("sb_e");
        idle(); #1;
        check("sb_clear", 32'(busy_c[0]), 32'h0);
        step("sb_f");

        // Flush overrides a simultaneous set.
        sb(5'd4); step("fl_a");
        sb(5'd6); step("fl_b");
        sb(5'd8); step("fl_c");
        idle(); rd(0, 5'd4); rd(1, 5'd8); #1;
        check("fl_busy4", 32'(busy_c[0]), 32'h1);
        check("fl_busy8", 32'(busy_c[1]), 32'h1);
        sb_flush = 1'b1; sb(5'd10);
        step("fl_d");
        idle(); rd(0, 5'd4); rd(1, 5'd6); #1;
        check("fl_r4", 32'(busy_c[0]), 32'h0);
        check("fl_r6", 32'(busy_c[1]), 32'h0);
        step("fl_e");
        rd(0, 5'd8); rd(1, 5'd10); #1;
        check("fl_r8", 32'(busy_c[0]), 32'h0);
        check("fl_r10", 32'(busy_c[1]), 32'h0);
        step("fl_f");

        // Random traffic, addresses biased to a small window to force collisions.
        repeat (400) begin
            for (int k = 0; k < NRD; k++)
                rd(k, 5'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, NR - 1)));
            for (int w = 0; w < NWR; w++) begin
                wen[w]              = 1'($urandom_range(0, 1));
                wr_addr[w*AW +: AW] = 5'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, NR - 1));
                wr_data[w*DW +: DW] = $urandom;
            end
            sb_set   = ($urandom_range(0, 2) == 0);
            sb_addr  = 5'($urandom_range(0, 7));
            sb_flush = ($urandom_range(0, 15) == 0);
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
